// File: rtl/mult_hilo_ctrl_if.sv
// Request channel from the execute stage into the HI/LO multiply controller.
// The master drives an op and its operands; the slave (controller) answers with ready.
interface mult_hilo_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;

  modport master (
    output req_valid, req_op, req_a, req_b,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b,
    output req_ready
  );
endinterface

// File: rtl/mult_hilo_ctrl.sv
// Issue/writeback controller for the iterative signed multiplier; owns HI/LO.
// Optional accumulate op (req_op 11 = MADD) is built only when MULT_HILO_MADD_EN is defined.
module mult_hilo_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  mult_hilo_ctrl_if.slave      req,
  output logic                 mult_begin,
  output logic [WIDTH-1:0]     mult_op1,
  output logic [WIDTH-1:0]     mult_op2,
  input  logic [2*WIDTH-1:0]   mult_product,
  input  logic                 mult_end,
  output logic [WIDTH-1:0]     hi,
  output logic [WIDTH-1:0]     lo,
  output logic                 busy,
  output logic                 done
);

  localparam int PW = 2 * WIDTH;
  localparam logic [1:0] OP_MTHI = 2'b01;
  localparam logic [1:0] OP_MTLO = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    GAP
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] op1_q, op1_d;
  logic [WIDTH-1:0] op2_q, op2_d;
  logic signed [PW-1:0] hilo_wb;

`ifdef MULT_HILO_MADD_EN
  localparam logic [1:0] OP_MADD = 2'b11;

  logic madd_q, madd_d;

  // Two's-complement accumulate; wraps modulo 2^PW by construction.
  function automatic logic signed [PW-1:0] acc_wrap(
    input logic signed [PW-1:0] acc,
    input logic signed [PW-1:0] prod
  );
    return acc + prod;
  endfunction

  assign hilo_wb = madd_q ? acc_wrap($signed({hi_q, lo_q}), $signed(mult_product))
                          : $signed(mult_product);
`else
  assign hilo_wb = $signed(mult_product);
`endif

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
`ifdef MULT_HILO_MADD_EN
    madd_d  = madd_q;
`endif
    case (state_q)
      IDLE: begin
        if (req.req_valid) begin
          case (req.req_op)
            OP_MTHI: hi_d = req.req_a;
            OP_MTLO: lo_d = req.req_a;
            default: begin
              op1_d   = req.req_a;
              op2_d   = req.req_b;
`ifdef MULT_HILO_MADD_EN
              madd_d  = (req.req_op == OP_MADD);
`endif
              state_d = RUN;
            end
          endcase
        end
      end
      RUN: begin
        if (mult_end) begin
          {hi_d, lo_d} = hilo_wb;
          state_d      = GAP;
        end
      end
      // Forced mult_begin-low cycle so the multiplier reloads on the next request.
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
`ifdef MULT_HILO_MADD_EN
      madd_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
`ifdef MULT_HILO_MADD_EN
      madd_q  <= madd_d;
`endif
    end
  end

  assign req.req_ready = (state_q == IDLE);
  assign busy          = (state_q != IDLE);
  assign mult_begin    = (state_q == RUN);
  assign done          = (state_q == GAP);
  assign mult_op1      = op1_q;
  assign mult_op2      = op2_q;
  assign hi            = hi_q;
  assign lo            = lo_q;

endmodule

// File: doc/mult_hilo_ctrl.md
Name: mult_hilo_ctrl

Overview:
- Issue/writeback stage around the 32-bit iterative signed multiplier (radix-4, variable latency, level-held `mult_begin`, one-cycle `mult_end`).
- Accepts MULT/MTHI/MTLO requests from the execute stage over a valid/ready handshake.
- Sequences the multiplier and holds the architectural HI/LO registers.
- Reports busy to the pipeline stall logic and pulses `done` on each multiply writeback.

Parameters:
- `WIDTH`, 32: operand width; HI/LO are each `WIDTH` bits, product is 2*`WIDTH`.

Ports:
- `clk` in 1: clock.
- `rst` in 1: synchronous reset, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: controller can accept a request.
- `req_op` in 2: 00 MULT, 01 MTHI, 10 MTLO, 11 MADD (see Optional Feature).
- `req_a` in WIDTH: operand A, or write data for MTHI/MTLO.
- `req_b` in WIDTH: operand B.
- `mult_begin` out 1: to the multiplier; level, held high until product capture.
- `mult_op1` out WIDTH: to multiplier `operand1`; registered copy of A.
- `mult_op2` out WIDTH: to multiplier `operand2`; registered copy of B.
- `mult_product` in 2*WIDTH: multiplier product, valid while `mult_end` = 1.
- `mult_end` in 1: multiplier completion, combinational from the multiplier.
- `hi` out WIDTH: HI register.
- `lo` out WIDTH: LO register.
- `busy` out 1: multiply in flight; equals `~req_ready`.
- `done` out 1: one-cycle pulse, the cycle after HI/LO update from a multiply.

Behaviour:
- Reset values: `hi` = 0, `lo` = 0, `mult_begin` = 0, `done` = 0, `req_ready` = 1, `mult_op1`/`mult_op2` = 0, state IDLE.
- Reset wins over every other event, including mid-multiply. The multiplier has no reset; IDLE keeps `mult_begin` low ≥ 1 cycle, which clears its internal valid.
- FSM states: IDLE, RUN, GAP.
- IDLE:
  - `req_ready` = 1.
  - On `req_valid & req_ready`:
    - MTHI: `hi <= req_a`; stay IDLE.
    - MTLO: `lo <= req_a`; stay IDLE.
    - MULT/MADD: latch `mult_op1 <= req_a`, `mult_op2 <= req_b`, latch the op; go RUN.
- RUN:
  - `mult_begin` = 1; `req_ready` = 0.
  - On `mult_end` = 1:
    - MULT: `{hi,lo} <= mult_product`.
    - MADD: `{hi,lo} <= {hi,lo} + mult_product`, modulo 2^(2*WIDTH).
    - Go GAP.
  - `mult_end` is ignored outside RUN.
- GAP:
  - `mult_begin` = 0, `done` = 1, `req_ready` = 0; next state IDLE.
  - The forced low cycle guarantees the multiplier reloads operands on the next request.
- Latency, with accept edge at end of cycle 0:
  - RUN from cycle 1.
  - `mult_end` in cycle 2+k, where k = ceil(bitlen(|B|)/2); k = 0 when B = 0.
  - HI/LO update at end of cycle 2+k; `done` in cycle 3+k; next accept possible in cycle 4+k.
- Back-to-back throughput is one multiply per 4+k cycles.
- MTHI/MTLO take one cycle each and may be accepted on consecutive cycles.
- `hi`/`lo` are stable (unchanged) throughout RUN; reads during busy see the old values.
- `req_*` inputs are ignored while `req_ready` = 0. The requester holds `req_valid` and its data until accepted.
- Signed semantics only; the operand pair -2^31 × -2^31 yields +2^62.

Optional Feature:
- Macro: `MULT_HILO_MADD_EN`.
- Defined: `req_op` 11 = MADD, accumulating the signed product into `{hi,lo}` as above, using one 64-bit adder.
- Undefined: `req_op` 11 behaves exactly as MULT (overwrite); no accumulate adder is built.

Test Plan:
- Reset, then MULT A=3, B=5 → `mult_begin` high cycles 1–4, `mult_end` cycle 4; `hi` = 0x00000000, `lo` = 0x0000000F; `done` cycle 5; `req_ready` back cycle 6.
- MULT A=-7 (0xFFFFFFF9), B=6 → `hi` = 0xFFFFFFFF, `lo` = 0xFFFFFFD6; `done` once, one cycle wide.
- MULT A=0x12345678, B=0 → `mult_end` cycle 2, `{hi,lo}` = 0, `done` cycle 3. Then MULT A=0x80000000, B=0x80000000 → `hi` = 0x40000000, `lo` = 0, `done` at cycle 19 relative to its accept.
- MTLO 0xA then MTHI 0xB on consecutive cycles → `lo` = 0xA, `hi` = 0xB, `req_ready` stays 1, `mult_begin` never asserts. A request held during RUN is not accepted until IDLE.
- With `MULT_HILO_MADD_EN` defined: MTLO 10, MTHI 0, MADD 2×3 → `lo` = 16, `hi` = 0. MADD -1×1 from `{hi,lo}` = 0 → `hi` = `lo` = 0xFFFFFFFF. Without the macro, the same sequence gives `lo` = 6, then `hi` = `lo` = 0xFFFFFFFF.
- Assert `rst` in cycle 3 of MULT 0x7FFFFFFF×0x7FFFFFFF → next cycle `hi` = `lo` = 0, `mult_begin` = 0, `done` = 0, `req_ready` = 1. A following MULT 4×4 returns `lo` = 16 with correct latency (no stale state).
